// File: rtl/multi_sel_seq.sv
// multi_sel_seq: operand-by-coefficient product sequencer; define MULTI_SEL_ACCUM_EN to add the running-sum acc port
module multi_sel_seq #(
  parameter int DW = 8,
  parameter int CW = 4,
  parameter int NCOEF = 4,
  parameter logic [NCOEF*CW-1:0] COEFS = {4'd8, 4'd7, 4'd3, 4'd1},
  localparam int OW = DW + CW,
  localparam int IW = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  input  logic          in_valid,
  output logic          input_grant,
  output logic [OW-1:0] out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last
`ifdef MULTI_SEL_ACCUM_EN
  ,
  output logic [OW+IW-1:0] acc
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [IW-1:0] LAST = IW'(NCOEF - 1);
  state_t r_state, w_next;
  logic [DW-1:0] r_op;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] w_coef;
  logic [OW-1:0] w_prod;
  logic w_accept, w_beat;
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_beat = (r_state == RUN) && out_ready;
  assign w_coef = COEFS[int'(r_idx)*CW +: CW];
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next state: accept moves to RUN, handshake on the last beat returns to IDLE
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_accept) w_next = RUN;
    if (r_state == RUN && w_beat && r_idx == LAST) w_next = IDLE;
  end
  // outputs decoded from registered state only
  always_comb begin
    input_grant = (r_state == IDLE);
    out_valid = (r_state == RUN);
    out_last = (r_state == RUN) && (r_idx == LAST);
    out_idx = r_idx;
    out = w_prod;
  end
  // operand capture and coefficient index stepping
  always_ff @(posedge clk)
    if (rst) begin
      r_op <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_op <= d;
      r_idx <= '0;
    end else if (w_beat)
      r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
  // shift-add product of the operand and the selected coefficient
  always_comb begin
    w_prod = '0;
    for (int b = 0; b < CW; b++)
      w_prod = w_prod + (w_coef[b] ? (OW'(r_op) << b) : '0);
  end
`ifdef MULTI_SEL_ACCUM_EN
  logic [OW+IW-1:0] r_acc;
  assign acc = r_acc;
  // running sum: cleared on accept, adds each product on its handshake
  always_ff @(posedge clk)
    if (rst || w_accept) r_acc <= '0;
    else if (w_beat) r_acc <= r_acc + (OW+IW)'(w_prod);
`endif
endmodule

// File: tb/tb_multi_sel_seq.sv
// tb_multi_sel_seq: directed and random stimulus against a product-queue reference model
module tb_multi_sel_seq;
  localparam int NC = 4;
  int coefs [NC] = '{1, 3, 7, 8};
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [7:0] d = 0;
  logic input_grant, out_valid, out_last;
  logic [11:0] out;
  logic [1:0] out_idx;
`ifdef MULTI_SEL_ACCUM_EN
  logic [13:0] acc;
`endif
  int checks = 0, failures = 0;
  int exp_q[$];
  int exp_acc = 0;
  bit armed = 0;
  multi_sel_seq dut (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .input_grant(input_grant),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last)
`ifdef MULTI_SEL_ACCUM_EN
    , .acc(acc)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic compare();
    int n = exp_q.size();
    chk("grant", 32'(input_grant), 32'(n == 0));
    chk("valid", 32'(out_valid), 32'(n != 0));
    if (n != 0) begin
      chk("out", 32'(out), exp_q[0]);
      chk("idx", 32'(out_idx), NC - n);
      chk("last", 32'(out_last), 32'(n == 1));
    end else
      chk("last_idle", 32'(out_last), 0);
`ifdef MULTI_SEL_ACCUM_EN
    chk("acc", 32'(acc), exp_acc);
`endif
  endtask
  task automatic step(input logic r, input logic v, input logic [7:0] dd, input logic rdy);
    @(negedge clk);
    if (armed) compare();
    rst = r; in_valid = v; d = dd; out_ready = rdy;
    @(posedge clk);
    if (r) begin
      exp_q.delete(); exp_acc = 0; armed = 1;
    end else if (exp_q.size() == 0) begin
      if (v) begin
        for (int i = 0; i < NC; i++) exp_q.push_back(int'(dd) * coefs[i]);
        exp_acc = 0;
      end
    end else if (rdy) begin
      exp_acc += exp_q[0];
      void'(exp_q.pop_front());
    end
  endtask
  task automatic job(input logic [7:0] dd);
    step(0, 1, dd, 1);
    for (int i = 0; i < NC + 1; i++) step(0, 0, 8'd0, 1);
  endtask
  initial begin
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_out", 32'(out), 0);
    chk("rst_idx", 32'(out_idx), 0);
    job(8'd5);
    job(8'd255);
    step(0, 1, 8'd7, 0);
    foreach (coefs[i]) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 1);
    step(0, 1, 8'd6, 1);
    for (int i = 0; i < NC + 3; i++) step(0, 1, 8'd1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 8'd5, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    job(8'd1);
    job(8'd0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, 1'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
    step(0, 0, 0, 1);
    @(negedge clk);
    compare();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
